fb_sched: RTL and testbench
===========================

FB_SCHED -- requirements
Module: fb_sched

Interface
REQ-001 SHALL have port: clk  in  1  single system clock, all logic on posedge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: clear_req  in  1  request full-screen clear (level or pulse, sampled each clk).
REQ-004 SHALL have port: draw_req  in  1  request one line draw by line engine.
REQ-005 SHALL have port: clr_reset  out  1  held high to park clear engine; low while clear engine runs.
REQ-006 SHALL have ports: clr_x in 10, clr_y in 9, clr_color in 1, clr_done in 1  clear-engine pixel stream.
REQ-007 SHALL have port: line_start  out  1  one-cycle start pulse to line engine.
REQ-008 SHALL have ports: line_x in 10, line_y in 9, line_color in 1, line_done in 1  line-engine pixel stream.
REQ-009 SHALL have ports: fb_x out 10, fb_y out 9, fb_color out 1, fb_we out 1  single framebuffer write port.
REQ-010 SHALL have port: busy  out  1  high whenever state is not IDLE.

Function
REQ-011 SHALL implement states IDLE, CLEAR, DRAW_GO, DRAW.
REQ-012 SHALL keep pending flags clr_pend, drw_pend; each set on any edge its request is high, single-depth (repeats while set are absorbed).
REQ-013 IDLE: clr_pend -> CLEAR; else drw_pend -> DRAW_GO; else stay. Clear wins when both pending.
REQ-014 clr_reset SHALL be 0 only in CLEAR, 1 in every other state.
REQ-015 CLEAR: when clr_done=1 -> IDLE and clr_pend cleared on same edge (unless clear_req high that edge, then stays set).
REQ-016 DRAW_GO: line_start=1 for exactly that one cycle, -> DRAW next edge, drw_pend cleared on that edge (same re-request rule as REQ-015).
REQ-017 DRAW: when line_done=1 -> IDLE; line_start=0.
REQ-018 Requests arriving during CLEAR or DRAW SHALL be held pending and served after return to IDLE; never abort current operation.
REQ-019 fb_x/fb_y/fb_color SHALL be registered copies of the active engine's stream (clear in CLEAR, line in DRAW), latency exactly 1 cycle.
REQ-020 fb_we SHALL be registered: 1 iff previous cycle state was CLEAR with clr_done=0, or DRAW with line_done=0, and the source x<640 and y<480.
REQ-021 Out-of-bounds pixels (x>=640 or y>=480) SHALL produce fb_we=0; coordinates still forwarded.
REQ-022 In IDLE and DRAW_GO, fb_we SHALL be 0 on the following cycle.
REQ-023 Minimum IDLE dwell between operations SHALL be one cycle.

Reset
REQ-024 On reset: state=IDLE, clr_pend=0, drw_pend=0, fb_x=0, fb_y=0, fb_color=0, fb_we=0, line_start=0, clr_reset=1, busy=0.
REQ-025 Reset mid-CLEAR or mid-DRAW SHALL abort immediately; requests high during reset are ignored.

Structure
REQ-026 Package fb_pkg SHALL hold SCREEN_W=640, SCREEN_H=480, X_W=10, Y_W=9, and the state enum.
REQ-027 One sub-module fb_port_reg SHALL implement the registered write port with bounds check (REQ-019..021); the FSM and pending flags stay in fb_sched.

Verification
REQ-028 Reset 3 cycles -> all outputs per REQ-024; clr_reset=1, busy=0.
REQ-029 clear_req pulse at edge 0 -> CLEAR at edge 1, clr_reset=0; clear engine stream x=3,y=7 -> fb_x=3, fb_y=7, fb_we=1 one cycle later; clr_done=1 -> IDLE, busy=0, fb_we=0 next cycle.
REQ-030 clear_req and draw_req same edge -> CLEAR served first, then IDLE one cycle, DRAW_GO with single line_start pulse, DRAW until line_done.
REQ-031 draw_req pulsed three times during CLEAR -> exactly one line_start after clear completes.
REQ-032 Clear engine emits x=640,y=0 before clr_done -> fb_x=640 forwarded, fb_we=0.
REQ-033 reset asserted mid-DRAW -> next edge IDLE, line_start=0, fb_we=0, pending flags 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared screen geometry, coordinate widths and scheduler state encoding
// for the framebuffer write scheduler.
package fb_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int X_W      = 10;
  localparam int Y_W      = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CLEAR   = 2'd1,
    DRAW_GO = 2'd2,
    DRAW    = 2'd3
  } fb_state_e;

  function automatic logic in_bounds(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (x < X_W'(SCREEN_W)) && (y < Y_W'(SCREEN_H));
  endfunction

endpackage

// File: rtl/fb_port_reg.sv
// Registered framebuffer write port: selects the active engine stream,
// forwards its coordinates one cycle later and gates the write on bounds.
module fb_port_reg
  import fb_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           sel_clr,
  input  logic           sel_line,
  input  logic [X_W-1:0] clr_x,
  input  logic [Y_W-1:0] clr_y,
  input  logic           clr_color,
  input  logic           clr_done,
  input  logic [X_W-1:0] line_x,
  input  logic [Y_W-1:0] line_y,
  input  logic           line_color,
  input  logic           line_done,
  output logic [X_W-1:0] fb_x,
  output logic [Y_W-1:0] fb_y,
  output logic           fb_color,
  output logic           fb_we
);

  logic [X_W-1:0] src_x;
  logic [Y_W-1:0] src_y;
  logic           src_color;
  logic           src_live;
  logic           src_sel;

  always_comb begin
    src_x     = line_x;
    src_y     = line_y;
    src_color = line_color;
    src_live  = ~line_done;
    src_sel   = sel_line;
    if (sel_clr) begin
      src_x     = clr_x;
      src_y     = clr_y;
      src_color = clr_color;
      src_live  = ~clr_done;
      src_sel   = 1'b1;
    end
  end

  // Coordinates hold their last value while no engine is selected.
  always_ff @(posedge clk) begin
    if (reset) begin
      fb_x     <= '0;
      fb_y     <= '0;
      fb_color <= 1'b0;
      fb_we    <= 1'b0;
    end else begin
      if (src_sel) begin
        fb_x     <= src_x;
        fb_y     <= src_y;
        fb_color <= src_color;
      end
      fb_we <= src_sel & src_live & in_bounds(src_x, src_y);
    end
  end

endmodule

// File: rtl/fb_sched.sv
// Framebuffer scheduler: arbitrates clear and line-draw requests, sequences
// the two pixel engines and muxes their streams onto one write port.
module fb_sched
  import fb_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           clear_req,
  input  logic           draw_req,
  output logic           clr_reset,
  input  logic [X_W-1:0] clr_x,
  input  logic [Y_W-1:0] clr_y,
  input  logic           clr_color,
  input  logic           clr_done,
  output logic           line_start,
  input  logic [X_W-1:0] line_x,
  input  logic [Y_W-1:0] line_y,
  input  logic           line_color,
  input  logic           line_done,
  output logic [X_W-1:0] fb_x,
  output logic [Y_W-1:0] fb_y,
  output logic           fb_color,
  output logic           fb_we,
  output logic           busy
);

  // Engine protocol: an engine's x/y/color are a valid pixel on every cycle
  // it is active and its done is low; done=1 ends the job and that cycle's
  // pixel is discarded. There is no backpressure toward the engines.

  fb_state_e state, state_nxt;
  logic      clr_pend, drw_pend;
  logic      clr_take, drw_take;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      clr_pend <= 1'b0;
      drw_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      // A request on the consuming edge re-arms the flag.
      clr_pend <= clear_req | (clr_pend & ~clr_take);
      drw_pend <= draw_req  | (drw_pend & ~drw_take);
    end
  end

  always_comb begin
    state_nxt  = state;
    clr_take   = 1'b0;
    drw_take   = 1'b0;
    clr_reset  = 1'b1;
    line_start = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (clr_pend)      state_nxt = CLEAR;
        else if (drw_pend) state_nxt = DRAW_GO;
      end
      CLEAR: begin
        clr_reset = 1'b0;
        if (clr_done) begin
          state_nxt = IDLE;
          clr_take  = 1'b1;
        end
      end
      DRAW_GO: begin
        line_start = 1'b1;
        drw_take   = 1'b1;
        state_nxt  = DRAW;
      end
      DRAW: begin
        if (line_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  fb_port_reg u_port (
    .clk        (clk),
    .reset      (reset),
    .sel_clr    (state == CLEAR),
    .sel_line   (state == DRAW),
    .clr_x      (clr_x),
    .clr_y      (clr_y),
    .clr_color  (clr_color),
    .clr_done   (clr_done),
    .line_x     (line_x),
    .line_y     (line_y),
    .line_color (line_color),
    .line_done  (line_done),
    .fb_x       (fb_x),
    .fb_y       (fb_y),
    .fb_color   (fb_color),
    .fb_we      (fb_we)
  );

endmodule

// File: tb/tb_fb_sched.sv
// Bench for fb_sched: directed scenarios with literal expectations, then
// randomized requests and engine streams checked every cycle against a model.
module tb_fb_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear_req, draw_req;
  logic       clr_reset, line_start, busy;
  logic [9:0] clr_x, line_x, fb_x;
  logic [8:0] clr_y, line_y, fb_y;
  logic       clr_color, clr_done, line_color, line_done;
  logic       fb_color, fb_we;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  fb_sched dut (
    .clk(clk), .reset(reset), .clear_req(clear_req), .draw_req(draw_req),
    .clr_reset(clr_reset), .clr_x(clr_x), .clr_y(clr_y), .clr_color(clr_color),
    .clr_done(clr_done), .line_start(line_start), .line_x(line_x), .line_y(line_y),
    .line_color(line_color), .line_done(line_done), .fb_x(fb_x), .fb_y(fb_y),
    .fb_color(fb_color), .fb_we(fb_we), .busy(busy)
  );

  // ---------------- behavioural model ----------------
  // Mode: 0 = waiting, 1 = clearing, 2 = issuing line start, 3 = drawing.
  int          m_mode = 0;
  bit          m_cp = 0, m_dp = 0;
  logic [9:0]  m_x = '0;
  logic [8:0]  m_y = '0;
  logic        m_c = 1'b0, m_we = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_cp = 0; m_dp = 0;
      m_x = '0; m_y = '0; m_c = 1'b0; m_we = 1'b0;
    end else begin
      bit done_c, took_d;
      done_c = 0; took_d = 0;
      m_we = 1'b0;
      if (m_mode == 1) begin
        m_x = clr_x; m_y = clr_y; m_c = clr_color;
        m_we = !clr_done && (int'(clr_x) < 640) && (int'(clr_y) < 480);
      end else if (m_mode == 3) begin
        m_x = line_x; m_y = line_y; m_c = line_color;
        m_we = !line_done && (int'(line_x) < 640) && (int'(line_y) < 480);
      end
      case (m_mode)
        0: m_mode = m_cp ? 1 : (m_dp ? 2 : 0);
        1: if (clr_done) begin m_mode = 0; done_c = 1; end
        2: begin m_mode = 3; took_d = 1; end
        default: if (line_done) m_mode = 0;
      endcase
      m_cp = clear_req || (m_cp && !done_c);
      m_dp = draw_req  || (m_dp && !took_d);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",       32'(busy),       32'(m_mode != 0));
      check("clr_reset",  32'(clr_reset),  32'(m_mode != 1));
      check("line_start", 32'(line_start), 32'(m_mode == 2));
      check("fb_x",       32'(fb_x),       32'(m_x));
      check("fb_y",       32'(fb_y),       32'(m_y));
      check("fb_color",   32'(fb_color),   32'(m_c));
      check("fb_we",      32'(fb_we),      32'(m_we));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    clear_req = 0; draw_req = 0;
    clr_x = '0; clr_y = '0; clr_color = 0; clr_done = 0;
    line_x = '0; line_y = '0; line_color = 0; line_done = 0;
  endtask

  int starts;

  initial begin
    reset = 1'b1;
    idle_inputs();
    // reset for three cycles
    repeat (3) tick();
    chk_en = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_clr_reset", 32'(clr_reset), 32'd1);
    check("rst_line_start", 32'(line_start), 32'd0);
    check("rst_fb_we", 32'(fb_we), 32'd0);
    check("rst_fb_x", 32'(fb_x), 32'd0);
    check("rst_fb_y", 32'(fb_y), 32'd0);
    reset = 1'b0;

    // single clear with one in-bounds pixel
    clear_req = 1; tick();
    check("clr_pend_idle", 32'(busy), 32'd0);
    clear_req = 0; tick();
    check("clr_busy", 32'(busy), 32'd1);
    check("clr_reset_low", 32'(clr_reset), 32'd0);
    clr_x = 10'd3; clr_y = 9'd7; clr_color = 1; tick();
    check("clr_px_x", 32'(fb_x), 32'd3);
    check("clr_px_y", 32'(fb_y), 32'd7);
    check("clr_px_we", 32'(fb_we), 32'd1);
    clr_done = 1; tick();
    check("clr_done_idle", 32'(busy), 32'd0);
    check("clr_done_we", 32'(fb_we), 32'd0);
    clr_done = 0; tick();
    check("idle_we", 32'(fb_we), 32'd0);

    // simultaneous requests: clear first, one idle cycle, then draw
    clear_req = 1; draw_req = 1; tick();
    clear_req = 0; draw_req = 0; tick();
    check("both_clear_first", 32'(clr_reset), 32'd0);
    clr_done = 1; tick();
    check("both_idle_gap", 32'(busy), 32'd0);
    check("both_no_start", 32'(line_start), 32'd0);
    clr_done = 0; tick();
    check("both_start", 32'(line_start), 32'd1);
    tick();
    check("both_start_once", 32'(line_start), 32'd0);
    check("both_drawing", 32'(busy), 32'd1);
    line_done = 1; tick();
    check("both_draw_end", 32'(busy), 32'd0);
    line_done = 0;

    // three draw pulses during a clear collapse into one line start
    clear_req = 1; tick();
    clear_req = 0; tick();
    for (int i = 0; i < 6; i++) begin
      draw_req = (i % 2 == 0);
      tick();
    end
    draw_req = 0; clr_done = 1; line_done = 1;
    starts = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      starts += int'(line_start);
    end
    check("absorb_starts", 32'(starts), 32'd1);
    check("absorb_idle", 32'(busy), 32'd0);
    clr_done = 0; line_done = 0;

    // out-of-bounds clear pixel is forwarded but not written
    clear_req = 1; tick();
    clear_req = 0; tick();
    clr_x = 10'd640; clr_y = 9'd0; tick();
    check("oob_x", 32'(fb_x), 32'd640);
    check("oob_we", 32'(fb_we), 32'd0);
    clr_x = 10'd639; clr_y = 9'd480; tick();
    check("oob_y_we", 32'(fb_we), 32'd0);
    clr_done = 1; tick();
    clr_done = 0;

    // reset in the middle of a draw with requests pending
    draw_req = 1; tick();
    draw_req = 0; tick();
    line_x = 10'd10; line_y = 9'd10; tick();
    clear_req = 1; draw_req = 1; tick();
    check("mid_draw_we", 32'(fb_we), 32'd1);
    reset = 1; tick();
    check("rst_draw_busy", 32'(busy), 32'd0);
    check("rst_draw_start", 32'(line_start), 32'd0);
    check("rst_draw_we", 32'(fb_we), 32'd0);
    reset = 0; clear_req = 0; draw_req = 0; tick(); tick();
    check("rst_pend_cleared", 32'(busy), 32'd0);
    idle_inputs();

    // randomized phase
    for (int i = 0; i < 4000; i++) begin
      reset      = ($urandom_range(0, 299) == 0);
      clear_req  = ($urandom_range(0, 19) == 0);
      draw_req   = ($urandom_range(0, 9) == 0);
      clr_x      = 10'($urandom_range(0, 700));
      clr_y      = 9'($urandom_range(0, 511));
      clr_color  = 1'($urandom);
      clr_done   = ($urandom_range(0, 11) == 0);
      line_x     = 10'($urandom_range(0, 700));
      line_y     = 9'($urandom_range(0, 511));
      line_color = 1'($urandom);
      line_done  = ($urandom_range(0, 7) == 0);
      tick();
    end
    idle_inputs();
    reset = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
